// File: rtl/mult_dispatch.sv
// Purpose : queues 64x64 operand pairs and issues them one at a time to an external multiplier.
// Latency : pair accepted -> start in 2 cycles when idle; done -> out_valid on the next edge.
// Backpressure: in_ready drops when the FIFO is full; a held result (out_valid) stalls issue.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             operand-pair handshake (in_mcand, in_mplier)
//   mcand, mplier, start          operands and one-cycle issue pulse to the multiplier
//   product, done                 multiplier result and completion level
//   out_valid/out_ready           result handshake (out_product)
//   op_count                      completed output transfers, only with MULT_DISPATCH_COUNT_EN
//
// Optional feature macro: MULT_DISPATCH_COUNT_EN (adds op_count output and counter).

module mult_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_mcand,
  input  logic [63:0] in_mplier,
  output logic [63:0] mcand,
  output logic [63:0] mplier,
  output logic        start,
  input  logic [63:0] product,
  input  logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product
`ifdef MULT_DISPATCH_COUNT_EN
  ,
  output logic [31:0] op_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    HOLD
  } state_t;

  state_t state_q, state_d;

  // Each entry stores {mcand, mplier}.
  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic [63:0] mcand_q, mplier_q;
  logic        out_valid_q;
  logic [63:0] out_product_q;

  logic push, pop, load_ops, capture, consume;

  assign in_ready    = (count_q != FULL_CNT);
  assign push        = in_valid && in_ready;
  assign mcand       = mcand_q;
  assign mplier      = mplier_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    pop      = 1'b0;
    load_ops = 1'b0;
    capture  = 1'b0;
    consume  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !out_valid_q) begin
          state_d  = ISSUE;
          load_ops = 1'b1;
        end
      end
      ISSUE: begin
        start   = 1'b1;
        pop     = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        // done may still be high from the previous operation; wait for it to
        // drop so the level we act on belongs to this multiply.
        if (!done) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (done) begin
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          consume = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by count_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_mcand, in_mplier};
  end

  // Operands are only loaded on IDLE->ISSUE, so they stay stable for the
  // whole multiply.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q       <= '0;
      mplier_q      <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      if (load_ops) begin
        mcand_q  <= mem_q[rd_ptr_q][127:64];
        mplier_q <= mem_q[rd_ptr_q][63:0];
      end
      if (capture) begin
        out_product_q <= product;
        out_valid_q   <= 1'b1;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MULT_DISPATCH_COUNT_EN
  logic [31:0] op_count_q;

  assign op_count = op_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_dispatch.sv
// Purpose : self-checking bench for mult_dispatch with a behavioural multiplier and queue model.
// Latency : not applicable (bench).
// Backpressure: out_ready is driven directed or randomly; pushes wait on in_ready with a bound.

module tb_mult_dispatch;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_mcand, in_mplier;
  logic [63:0] mcand, mplier;
  logic        start;
  logic [63:0] product;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
`ifdef MULT_DISPATCH_COUNT_EN
  logic [31:0] op_count;
  int          op_exp = 0;
`endif

  mult_dispatch #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mcand   (in_mcand),
    .in_mplier  (in_mplier),
    .mcand      (mcand),
    .mplier     (mplier),
    .start      (start),
    .product    (product),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product)
`ifdef MULT_DISPATCH_COUNT_EN
    ,
    .op_count   (op_count)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: pairs accepted but not yet issued, and results issued
  // but not yet delivered, both in acceptance order.
  logic [63:0] acc_a[$], acc_b[$];
  logic [63:0] exp_res[$];
  logic [63:0] hs_log[$];
  int          n_starts = 0;
  int          hs_count = 0;

  // Multiplier model state.
  bit          mult_busy  = 1'b0;
  bit          mult_abort = 1'b0;
  int          mult_lat   = 0;
  int          force_lat  = 0;
  logic [63:0] ma, mb;
  bit          rand_on    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clock) begin
    if (reset) begin
      acc_a.delete();
      acc_b.delete();
      exp_res.delete();
      mult_abort = 1'b1;
`ifdef MULT_DISPATCH_COUNT_EN
      op_exp = 0;
`endif
    end else begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (acc_a.size() != DEPTH)});
`ifdef MULT_DISPATCH_COUNT_EN
      chk("op_count", {32'b0, op_count}, 64'(op_exp));
`endif
      if (start) begin
        n_starts++;
        chk("start_while_out_valid", {63'b0, out_valid}, 64'd0);
        if (acc_a.size() == 0) begin
          fail_now("start_with_empty_model");
        end else begin
          chk("issue_mcand", mcand, acc_a[0]);
          chk("issue_mplier", mplier, acc_b[0]);
          exp_res.push_back(acc_a[0] * acc_b[0]);
          void'(acc_a.pop_front());
          void'(acc_b.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        acc_a.push_back(in_mcand);
        acc_b.push_back(in_mplier);
      end
      if (out_valid && out_ready) begin
        if (exp_res.size() == 0) begin
          fail_now("result_with_empty_model");
        end else begin
          chk("out_product", out_product, exp_res[0]);
          void'(exp_res.pop_front());
        end
        hs_log.push_back(out_product);
        hs_count++;
`ifdef MULT_DISPATCH_COUNT_EN
        op_exp++;
`endif
      end
    end
  end

  // Multiplier: drops done on start, raises it with a*b after 2..5 cycles,
  // then holds the level until the next start.
  initial begin
    done    = 1'b0;
    product = '0;
    forever begin
      @(posedge clock);
      #1;
      if (start) begin
        ma         = mcand;
        mb         = mplier;
        done       = 1'b0;
        mult_busy  = 1'b1;
        mult_abort = 1'b0;
        mult_lat   = (force_lat != 0) ? force_lat : int'($urandom_range(5, 2));
      end else if (mult_busy) begin
        mult_lat--;
        if (mult_lat == 0) begin
          if (!mult_abort) begin
            chk("mcand_stable", mcand, ma);
            chk("mplier_stable", mplier, mb);
          end
          product   = ma * mb;
          done      = 1'b1;
          mult_busy = 1'b0;
        end
      end
    end
  end

  // Random out_ready during the soak phase.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_on) out_ready = ($urandom_range(3, 0) != 0);
    end
  end

  task automatic push(input logic [63:0] a, input logic [63:0] b, input int bound, output bit ok);
    in_valid  = 1'b1;
    in_mcand  = a;
    in_mplier = b;
    ok        = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int bound, input string nm);
    for (int i = 0; i < bound && hs_count < target; i++) begin
      @(posedge clock);
      #2;
    end
    if (hs_count < target) fail_now(nm);
  endtask

  initial begin
    bit ok;
    int s0, h0, acc, pushed;
    logic [63:0] ra, rb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mcand  = '0;
    in_mplier = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clock);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_start", {63'b0, start}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_mcand", mcand, 64'd0);
    chk("rst_mplier", mplier, 64'd0);
    @(posedge clock);
    #1;

    // Single multiply 2*3.
    s0 = n_starts;
    h0 = hs_count;
    push(64'd2, 64'd3, 10, ok);
    chk("push_2x3_ok", {63'b0, ok}, 64'd1);
    wait_hs(h0 + 1, 50, "wait_2x3");
    chk("result_2x3", hs_log[hs_log.size() - 1], 64'd6);
    chk("out_valid_one_cycle", {63'b0, out_valid}, 64'd0);
    chk("starts_2x3", 64'(n_starts - s0), 64'd1);

    // Signed-looking operands, back to back.
    s0 = n_starts;
    h0 = hs_count;
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 10, ok);
    chk("push_neg1_ok", {63'b0, ok}, 64'd1);
    push(64'hFFFF_FFFF_FFFF_FFEC, 64'd5, 10, ok);
    chk("push_neg20_ok", {63'b0, ok}, 64'd1);
    wait_hs(h0 + 2, 80, "wait_neg");
    chk("result_neg1x3", hs_log[h0], 64'hFFFF_FFFF_FFFF_FFFD);
    chk("result_neg20x5", hs_log[h0 + 1], 64'hFFFF_FFFF_FFFF_FF9C);
    chk("starts_neg", 64'(n_starts - s0), 64'd2);

    // Backpressure: fill the FIFO plus the result slot.
    out_ready = 1'b0;
    s0  = n_starts;
    h0  = hs_count;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(64'(i + 1), 64'(i + 100), 20, ok);
      if (ok) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'(DEPTH + 1));
    chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_single_start", 64'(n_starts - s0), 64'd1);
    out_ready = 1'b1;
    wait_hs(h0 + DEPTH + 1, 300, "wait_bp_drain");
    chk("bp_first", hs_log[h0], 64'd100);
    chk("bp_last", hs_log[h0 + DEPTH], 64'd520);
    chk("bp_in_ready_high", {63'b0, in_ready}, 64'd1);

    // Reset while waiting for done; the late done must not produce a result.
    force_lat = 12;
    s0 = n_starts;
    push(64'd7, 64'd9, 10, ok);
    for (int i = 0; i < 20 && n_starts == s0; i++) begin
      @(posedge clock);
      #2;
    end
    if (n_starts == s0) fail_now("wait_start_rst");
    push(64'd1, 64'd1, 10, ok);
    push(64'd2, 64'd2, 10, ok);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    force_lat = 0;
    s0 = n_starts;
    h0 = hs_count;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #2;
      chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
    end
    chk("rst_mid_no_start", 64'(n_starts - s0), 64'd0);
    chk("rst_mid_no_result", 64'(hs_count - h0), 64'd0);

    // Recovery with stale done still high from the aborted multiply.
    push(64'd3, 64'd4, 10, ok);
    wait_hs(h0 + 1, 50, "wait_recover");
    chk("result_3x4", hs_log[hs_log.size() - 1], 64'd12);

    // Random soak.
    h0      = hs_count;
    pushed  = 0;
    rand_on = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 7 == 0) rb = 64'($urandom_range(9, 0));
      push(ra, rb, 200, ok);
      if (ok) pushed++;
      else fail_now("soak_push");
      if ($urandom_range(3, 0) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    rand_on   = 1'b0;
    @(posedge clock);
    #1 out_ready = 1'b1;
    wait_hs(h0 + pushed, 400, "wait_soak_drain");
    chk("soak_count", 64'(hs_count - h0), 64'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
